// File: rtl/simon_pad.sv
// Player-side front end of the Simon game: button sync/debounce, press encoding
// with turn lockout and idle timeout, and lamp drive (playback, player, game-over flash).
module simon_pad #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES  = 300,
    parameter int FLASH_HALF      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       simonTurn,
    input  logic [1:0] simonNum,
    input  logic       simonPressed,
    input  logic       gameOver,
    output logic [1:0] playerNum,
    output logic       playerPressed,
    output logic [3:0] led,
    output logic       timeout,
    output logic       multiPress
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FL_W   = $clog2(FLASH_HALF + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {LOCKED, WAIT_UP, ARMED, HELD} state_t;

    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      db_q;
    logic [DB_W-1:0] db_cnt_q [4];

    state_t            state_q;
    logic [1:0]        num_q;
    logic              pressed_q;
    logic              multi_q;
    logic              timeout_q;
    logic [IDLE_W-1:0] idle_q;

    logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
    logic            flash_on_q, flash_on_d;
    logic            game_over_q;
    logic [3:0]      led_q, led_d;

    logic [2:0] db_count;
    logic [1:0] db_idx;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: the small counter array is reset explicitly; it is control state, not storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= ~db_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        db_count = '0;
        db_idx   = '0;
        for (int i = 0; i < 4; i++) begin
            if (db_q[i]) begin
                db_count = db_count + 3'd1;
                db_idx   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= LOCKED;
            num_q     <= '0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            multi_q <= 1'b0;
            if (gameOver || simonTurn) begin
                state_q   <= LOCKED;
                pressed_q <= 1'b0;
                timeout_q <= 1'b0;
                idle_q    <= '0;
            end else begin
                case (state_q)
                    LOCKED:  state_q <= WAIT_UP;
                    // A button still held from the previous turn must be released first.
                    WAIT_UP: if (db_q == 4'b0000) state_q <= ARMED;
                    ARMED: begin
                        if (db_count == 3'd1) begin
                            num_q     <= db_idx;
                            pressed_q <= 1'b1;
                            state_q   <= HELD;
                            idle_q    <= '0;
                        end else if (db_count > 3'd1) begin
                            multi_q <= 1'b1;
                            state_q <= WAIT_UP;
                            idle_q  <= '0;
                        end else begin
                            if (idle_q != IDLE_MAX) idle_q <= idle_q + IDLE_W'(1);
                            if (idle_q >= IDLE_LAST) timeout_q <= 1'b1;
                        end
                    end
                    HELD: begin
                        if (!db_q[num_q]) begin
                            pressed_q <= 1'b0;
                            state_q   <= ARMED;
                        end
                    end
                    default: state_q <= LOCKED;
                endcase
            end
        end
    end

    always_comb begin
        flash_cnt_d = '0;
        flash_on_d  = 1'b0;
        led_d       = 4'b0000;
        if (gameOver) begin
            if (!game_over_q) begin
                flash_on_d = 1'b1;
            end else if (flash_cnt_q == FL_LAST) begin
                flash_on_d = ~flash_on_q;
            end else begin
                flash_cnt_d = flash_cnt_q + FL_W'(1);
                flash_on_d  = flash_on_q;
            end
            led_d = {4{flash_on_d}};
        end else if (simonTurn) begin
            led_d = simonPressed ? (4'b0001 << simonNum) : 4'b0000;
        end else begin
            led_d = pressed_q ? (4'b0001 << num_q) : 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
            game_over_q <= 1'b0;
            led_q       <= '0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_on_q  <= flash_on_d;
            game_over_q <= gameOver;
            led_q       <= led_d;
        end
    end

    assign playerNum     = num_q;
    assign playerPressed = pressed_q;
    assign led           = led_q;
    assign timeout       = timeout_q;
    assign multiPress    = multi_q;

endmodule

// File: tb/tb_simon_pad.sv
// Self-checking bench for simon_pad: expected presses are queued when buttons are
// driven and compared when playerPressed rises; direct checks cover timing and lamps.
module tb_simon_pad;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       simonTurn;
    logic [1:0] simonNum;
    logic       simonPressed;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic [3:0] led;
    logic       timeout;
    logic       multiPress;

    int vectors     = 0;
    int miscompares = 0;
    int multi_seen  = 0;
    logic [1:0] exp_press_q [$];
    logic pressed_prev = 1'b0;
    logic multi_prev   = 1'b0;

    simon_pad dut (
        .clk(clk), .reset(reset), .btn(btn), .simonTurn(simonTurn),
        .simonNum(simonNum), .simonPressed(simonPressed), .gameOver(gameOver),
        .playerNum(playerNum), .playerPressed(playerPressed), .led(led),
        .timeout(timeout), .multiPress(multiPress)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: each press rise consumes one queued expectation.
    always @(negedge clk) begin
        if (playerPressed && !pressed_prev) begin
            check("press_expected", 32'(exp_press_q.size() > 0), 1);
            if (exp_press_q.size() > 0) check("press_num_sb", playerNum, exp_press_q.pop_front());
        end
        if (multiPress && !multi_prev) multi_seen++;
        pressed_prev = playerPressed;
        multi_prev   = multiPress;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; btn = '0; simonTurn = 1'b0; simonNum = '0;
        simonPressed = 1'b0; gameOver = 1'b0;
        cycles(2);
        check("rst_pressed", playerPressed, 0);
        check("rst_num", playerNum, 0);
        check("rst_led", led, 0);
        check("rst_timeout", timeout, 0);
        check("rst_multi", multiPress, 0);
        reset = 1'b0;
        cycles(4);

        // Clean press of colour 2, held 20 cycles.
        exp_press_q.push_back(2'd2);
        btn = 4'b0100;
        cycles(5);
        check("press_lat_early", playerPressed, 0);
        cycles(1);
        check("press_lat", playerPressed, 1);
        check("press_num", playerNum, 2);
        cycles(1);
        check("press_led", led, 4'b0100);
        cycles(13);
        btn = 4'b0000;
        cycles(5);
        check("rel_lat_early", playerPressed, 1);
        cycles(1);
        check("rel_lat", playerPressed, 0);
        check("rel_num_hold", playerNum, 2);
        cycles(1);
        check("rel_led", led, 4'b0000);
        cycles(4);

        // Bounce on btn[1], then a clean hold.
        for (int i = 0; i < 5; i++) begin
            btn = 4'b0010; cycles(1);
            btn = 4'b0000; cycles(1);
        end
        check("bounce_no_press", playerPressed, 0);
        exp_press_q.push_back(2'd1);
        btn = 4'b0010;
        cycles(10);
        check("bounce_pressed", playerPressed, 1);
        check("bounce_num", playerNum, 1);
        btn = 4'b0000;
        cycles(10);

        // Two buttons in the same cycle.
        btn = 4'b0011;
        cycles(5);
        check("multi_early", multiPress, 0);
        cycles(1);
        check("multi_pulse", multiPress, 1);
        check("multi_no_press", playerPressed, 0);
        cycles(1);
        check("multi_one_cycle", multiPress, 0);
        btn = 4'b0000;
        cycles(10);
        exp_press_q.push_back(2'd3);
        btn = 4'b1000;
        cycles(8);
        check("after_multi_num", playerNum, 3);
        check("after_multi_pressed", playerPressed, 1);
        btn = 4'b0000;
        cycles(10);

        // Button held across the end of Simon's turn.
        simonTurn = 1'b1;
        btn = 4'b0001;
        cycles(10);
        simonTurn = 1'b0;
        cycles(20);
        check("lockout_no_press", playerPressed, 0);
        btn = 4'b0000;
        cycles(10);
        exp_press_q.push_back(2'd0);
        btn = 4'b0001;
        cycles(8);
        check("repress_pressed", playerPressed, 1);
        check("repress_num", playerNum, 0);
        simonTurn = 1'b1; simonNum = 2'd3; simonPressed = 1'b1;
        cycles(1);
        check("turn_drop_press", playerPressed, 0);
        check("simon_led", led, 4'b1000);
        simonPressed = 1'b0;
        cycles(1);
        check("simon_led_off", led, 4'b0000);
        btn = 4'b0000;
        cycles(10);

        // Idle timeout in ARMED.
        check("timeout_clear_start", timeout, 0);
        simonTurn = 1'b0;
        cycles(295);
        check("timeout_early", timeout, 0);
        cycles(10);
        check("timeout_set", timeout, 1);
        exp_press_q.push_back(2'd2);
        btn = 4'b0100;
        cycles(8);
        check("timeout_press", playerPressed, 1);
        check("timeout_sticky", timeout, 1);
        btn = 4'b0000;
        cycles(8);
        simonTurn = 1'b1;
        cycles(1);
        check("timeout_cleared", timeout, 0);
        simonTurn = 1'b0;
        cycles(5);

        // Game-over flash: F for 15 cycles, 0 for 15, and so on.
        gameOver = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            cycles(1);
            check("flash_led", led, (((k - 1) / 15) % 2 == 0) ? 4'hF : 4'h0);
            check("gameover_no_press", playerPressed, 0);
            if (k == 5) btn = 4'b0010;
        end
        gameOver = 1'b0;
        btn = 4'b0000;
        cycles(12);

        // Asynchronous reset in the middle of a press.
        exp_press_q.push_back(2'd1);
        btn = 4'b0010;
        cycles(8);
        check("pre_reset_pressed", playerPressed, 1);
        check("pre_reset_led", led, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pressed", playerPressed, 0);
        check("async_rst_led", led, 0);
        check("async_rst_num", playerNum, 0);
        @(negedge clk);
        reset = 1'b0;
        btn = 4'b0000;
        cycles(5);

        check("press_queue_empty", exp_press_q.size(), 0);
        check("multi_pulse_count", multi_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
